// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// decode-stage misprediction detection and branch/mispredict statistics.
module branch_predictor #(
   parameter int IDX_BITS = 4,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         PCF,
   input  logic                StallF,
   input  logic                FlushD,
   input  logic                BranchD,
   input  logic                BranchTakenD,
   input  logic [31:0]         PCBranchD,
   input  logic [31:0]         PCPlus4D,
   output logic                PredTakenF,
   output logic [31:0]         PredTargetF,
   output logic                MispredictD,
   output logic [31:0]         RecoverPCD,
   output logic [CNT_BITS-1:0] BranchCount,
   output logic [CNT_BITS-1:0] MispredCount
);

   localparam int N     = 1 << IDX_BITS;
   localparam int TAG_W = 30 - IDX_BITS;

   logic             valid_q [N];
   logic [1:0]       cnt_q   [N];
   logic [31:0]      tgt_q   [N];
   logic [TAG_W-1:0] tag_q   [N];

   logic             ptd_q, ptd_d;
   logic [31:0]      ptgt_q, ptgt_d;
   logic [31:2]      pcd_q, pcd_d;
   logic [CNT_BITS-1:0] bcnt_q, bcnt_d;
   logic [CNT_BITS-1:0] mcnt_q, mcnt_d;

   logic [IDX_BITS-1:0] f_idx, d_idx;
   logic [TAG_W-1:0]    f_tag, d_tag;
   logic                d_hit, upd;
   logic                unused_pc;

   logic             ent_we;
   logic             ent_valid_d;
   logic [1:0]       ent_cnt_d;
   logic [31:0]      ent_tgt_d;
   logic [TAG_W-1:0] ent_tag_d;

   assign unused_pc = ^PCF[1:0];

   assign f_idx = PCF[IDX_BITS+1:2];
   assign f_tag = PCF[31:IDX_BITS+2];
   assign d_idx = pcd_q[IDX_BITS+1:2];
   assign d_tag = pcd_q[31:IDX_BITS+2];

   // Lookup reads the registered table, so a same-cycle update is not seen.
   assign PredTakenF  = valid_q[f_idx] && (tag_q[f_idx] == f_tag)
                        && cnt_q[f_idx][1];
   assign PredTargetF = PredTakenF ? tgt_q[f_idx] : 32'h0;

   assign MispredictD = BranchD && !FlushD &&
                        ((ptd_q != BranchTakenD) ||
                         (ptd_q && BranchTakenD && (ptgt_q != PCBranchD)));
   assign RecoverPCD  = BranchTakenD ? PCBranchD : PCPlus4D;

   assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
   assign upd   = BranchD && !FlushD && !StallF;

   assign BranchCount  = bcnt_q;
   assign MispredCount = mcnt_q;

   always_comb begin
      ptd_d  = ptd_q;
      ptgt_d = ptgt_q;
      pcd_d  = pcd_q;
      if (!StallF) begin
         ptd_d  = PredTakenF;
         ptgt_d = PredTargetF;
         pcd_d  = PCF[31:2];
      end
      if (FlushD) ptd_d = 1'b0;
   end

   always_comb begin
      ent_we      = 1'b0;
      ent_valid_d = valid_q[d_idx];
      ent_cnt_d   = cnt_q[d_idx];
      ent_tgt_d   = tgt_q[d_idx];
      ent_tag_d   = tag_q[d_idx];
      if (upd) begin
         if (d_hit) begin
            ent_we = 1'b1;
            if (BranchTakenD) begin
               ent_tgt_d = PCBranchD;
               if (cnt_q[d_idx] != 2'b11) ent_cnt_d = cnt_q[d_idx] + 2'b01;
            end else if (cnt_q[d_idx] != 2'b00) begin
               ent_cnt_d = cnt_q[d_idx] - 2'b01;
            end
         end else if (BranchTakenD) begin
            // Allocate on a taken miss; not-taken misses leave the entry alone.
            ent_we      = 1'b1;
            ent_valid_d = 1'b1;
            ent_tag_d   = d_tag;
            ent_tgt_d   = PCBranchD;
            ent_cnt_d   = 2'b10;
         end
      end
   end

   always_comb begin
      bcnt_d = bcnt_q;
      mcnt_d = mcnt_q;
      if (upd && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_BITS'(1);
      if (upd && MispredictD && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_BITS'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= 2'b01;
            tgt_q[i]   <= 32'h0;
            tag_q[i]   <= '0;
         end
         ptd_q  <= 1'b0;
         ptgt_q <= 32'h0;
         pcd_q  <= '0;
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         if (ent_we) begin
            valid_q[d_idx] <= ent_valid_d;
            cnt_q[d_idx]   <= ent_cnt_d;
            tgt_q[d_idx]   <= ent_tgt_d;
            tag_q[d_idx]   <= ent_tag_d;
         end
         ptd_q  <= ptd_d;
         ptgt_q <= ptgt_d;
         pcd_q  <= pcd_d;
         bcnt_q <= bcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: cold miss, hysteresis, stall/flush,
// aliasing, same-index read/update, counter saturation and mid-run reset.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PCF;
   logic        StallF, FlushD, BranchD, BranchTakenD;
   logic [31:0] PCBranchD, PCPlus4D;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        MispredictD;
   logic [31:0] RecoverPCD;
   logic [15:0] BranchCount, MispredCount;

   int checks = 0;
   int fails  = 0;

   branch_predictor #(.IDX_BITS(4), .CNT_BITS(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PCF          (PCF),
      .StallF       (StallF),
      .FlushD       (FlushD),
      .BranchD      (BranchD),
      .BranchTakenD (BranchTakenD),
      .PCBranchD    (PCBranchD),
      .PCPlus4D     (PCPlus4D),
      .PredTakenF   (PredTakenF),
      .PredTargetF  (PredTargetF),
      .MispredictD  (MispredictD),
      .RecoverPCD   (RecoverPCD),
      .BranchCount  (BranchCount),
      .MispredCount (MispredCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic st, input logic fl,
                        input logic br, input logic tk,
                        input logic [31:0] tgt, input logic [31:0] p4);
      PCF = pc; StallF = st; FlushD = fl;
      BranchD = br; BranchTakenD = tk; PCBranchD = tgt; PCPlus4D = p4;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h44);
      tick(); tick();
      drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rst_predtaken", {31'b0, PredTakenF}, 32'd0);
      chk("rst_predtarget", PredTargetF, 32'h0);
      chk("rst_mispredict", {31'b0, MispredictD}, 32'd0);
      chk("rst_bcnt", {16'b0, BranchCount}, 32'd0);
      chk("rst_mcnt", {16'b0, MispredCount}, 32'd0);
      rst_n = 1'b1;
      tick();

      // cold miss at 0x40, taken to 0x20; same-cycle lookup sees old entry
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h44);
      chk("cold_mispredict", {31'b0, MispredictD}, 32'd1);
      chk("cold_recover", RecoverPCD, 32'h20);
      chk("same_idx_old", {31'b0, PredTakenF}, 32'd0);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("same_idx_new", {31'b0, PredTakenF}, 32'd1);
      chk("alloc_target", PredTargetF, 32'h20);
      chk("cold_bcnt", {16'b0, BranchCount}, 32'd1);
      chk("cold_mcnt", {16'b0, MispredCount}, 32'd1);
      tick();

      // hysteresis: WT -NT-> WNT -T-> WT -T-> ST
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h44);
      chk("nt_mispredict", {31'b0, MispredictD}, 32'd1);
      chk("nt_recover", RecoverPCD, 32'h44);
      chk("wt_pred", {31'b0, PredTakenF}, 32'd1);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h44);
      chk("wnt_pred", {31'b0, PredTakenF}, 32'd0);
      chk("correct_taken", {31'b0, MispredictD}, 32'd0);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h44);
      chk("wt_again_pred", {31'b0, PredTakenF}, 32'd1);
      chk("pred_nt_was_t", {31'b0, MispredictD}, 32'd1);
      tick();
      // four not-taken from ST
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h44);
      chk("st_pred", {31'b0, PredTakenF}, 32'd1);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h44);
      chk("st_wt_pred", {31'b0, PredTakenF}, 32'd1);
      chk("nt2_mispredict", {31'b0, MispredictD}, 32'd1);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h44);
      chk("st_wnt_pred", {31'b0, PredTakenF}, 32'd0);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h44);
      chk("snt_pred", {31'b0, PredTakenF}, 32'd0);
      chk("nt_correct", {31'b0, MispredictD}, 32'd0);
      tick();
      // one taken from a saturated SNT only reaches WNT
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h44);
      chk("sat_snt_pred", {31'b0, PredTakenF}, 32'd0);
      chk("sat_mispredict", {31'b0, MispredictD}, 32'd1);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("snt_to_wnt", {31'b0, PredTakenF}, 32'd0);
      chk("hyst_bcnt", {16'b0, BranchCount}, 32'd9);
      chk("hyst_mcnt", {16'b0, MispredCount}, 32'd7);
      tick();

      // stall: mispredict still visible, no update, no count
      drive(32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h44);
      chk("stall_mispredict", {31'b0, MispredictD}, 32'd1);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("stall_no_update", {31'b0, PredTakenF}, 32'd0);
      chk("stall_bcnt", {16'b0, BranchCount}, 32'd9);
      chk("stall_mcnt", {16'b0, MispredCount}, 32'd7);
      tick();
      // flush: squashed branch neither mispredicts nor updates
      drive(32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h44);
      chk("flush_mispredict", {31'b0, MispredictD}, 32'd0);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("flush_no_update", {31'b0, PredTakenF}, 32'd0);
      chk("flush_bcnt", {16'b0, BranchCount}, 32'd9);
      tick();

      // aliasing: bring 0x40 to WT, then 0x80 replaces index 0
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h44);
      tick();
      drive(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("alias_tag_miss", {31'b0, PredTakenF}, 32'd0);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h84);
      chk("alias_old_pred", {31'b0, PredTakenF}, 32'd1);
      chk("alias_old_tgt", PredTargetF, 32'h20);
      chk("alias_mispredict", {31'b0, MispredictD}, 32'd1);
      chk("alias_recover", RecoverPCD, 32'h100);
      tick();
      drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("alias_evicted", {31'b0, PredTakenF}, 32'd0);
      drive(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("alias_new_pred", {31'b0, PredTakenF}, 32'd1);
      chk("alias_new_tgt", PredTargetF, 32'h100);
      chk("alias_bcnt", {16'b0, BranchCount}, 32'd11);
      chk("alias_mcnt", {16'b0, MispredCount}, 32'd9);
      tick();

      // saturate the branch counter with correctly predicted branches
      drive(32'h80, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h84);
      for (int i = 0; i < 65540; i++) tick();
      chk("sat_bcnt", {16'b0, BranchCount}, 32'hFFFF);
      chk("sat_mcnt", {16'b0, MispredCount}, 32'd9);
      tick();
      chk("sat_bcnt_hold", {16'b0, BranchCount}, 32'hFFFF);

      // mid-run reset overrides a simultaneous update
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rerst_bcnt", {16'b0, BranchCount}, 32'd0);
      chk("rerst_mcnt", {16'b0, MispredCount}, 32'd0);
      chk("rerst_pred80", {31'b0, PredTakenF}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         drive(32'h40 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         chk("rerst_pred", {31'b0, PredTakenF}, 32'd0);
         chk("rerst_tgt", PredTargetF, 32'h0);
      end
      drive(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("rerst_mispredict", {31'b0, MispredictD}, 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, meaning log2 of table entries (16 entries).
REQ-002 SHALL have parameter CNT_BITS, default 16, meaning width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; synchronous and active-low.
REQ-005 SHALL have port PCF, input, 32, meaning fetch-stage PC to predict.
REQ-006 SHALL have port StallF, input, 1, meaning fetch/decode boundary held this cycle.
REQ-007 SHALL have port FlushD, input, 1, meaning the decode-stage instruction is squashed.
REQ-008 SHALL have port BranchD, input, 1, meaning the decode-stage instruction is a conditional branch resolving this cycle.
REQ-009 SHALL have port BranchTakenD, input, 1, meaning resolved direction of the decode-stage branch.
REQ-010 SHALL have port PCBranchD, input, 32, meaning resolved target of the decode-stage branch.
REQ-011 SHALL have port PCPlus4D, input, 32, meaning decode-stage PC+4.
REQ-012 SHALL have port PredTakenF, output, 1, meaning predicted taken for PCF.
REQ-013 SHALL have port PredTargetF, output, 32, meaning predicted target for PCF (0 when PredTakenF=0).
REQ-014 SHALL have port MispredictD, output, 1, meaning the decode-stage prediction was wrong; fetch must redirect and flush.
REQ-015 SHALL have port RecoverPCD, output, 32, meaning correct next PC when MispredictD=1.
REQ-016 SHALL have port BranchCount, output, CNT_BITS, meaning resolved branches since reset.
REQ-017 SHALL have port MispredCount, output, CNT_BITS, meaning mispredictions since reset.

Function
REQ-018 SHALL hold 2^IDX_BITS entries, each: valid bit, 2-bit counter, 32-bit target, tag PC[31:IDX_BITS+2].
REQ-019 SHALL index the table by PC[IDX_BITS+1:2] for both lookup and update.
REQ-020 SHALL drive PredTakenF combinationally = entry valid AND tag match AND counter[1]=1; PredTargetF = entry target when PredTakenF=1, else 0.
REQ-021 SHALL register PredTakenF, PredTargetF, PCF into decode-stage copies (PredTakenD, PredTargetD, PCD) each cycle StallF=0; hold them when StallF=1; clear PredTakenD to 0 when FlushD=1 (FlushD has priority over StallF).
REQ-022 SHALL assert MispredictD combinationally when BranchD=1 and FlushD=0 and (PredTakenD != BranchTakenD, or PredTakenD=BranchTakenD=1 with PredTargetD != PCBranchD).
REQ-023 SHALL drive RecoverPCD = PCBranchD if BranchTakenD=1, else PCPlus4D; value is don't-care when MispredictD=0.
REQ-024 SHALL update the indexed entry on the clock edge when BranchD=1, FlushD=0, StallF=0: counter states SNT=00, WNT=01, WT=10, ST=11; taken increments, not-taken decrements, saturating at 11 and 00.
REQ-025 SHALL, on update with tag mismatch or invalid entry, allocate only if taken: valid=1, tag written, target=PCBranchD, counter=WT; not-taken on a miss leaves the entry unchanged.
REQ-026 SHALL, on taken update with tag hit, overwrite target with PCBranchD.
REQ-027 SHALL give a same-cycle lookup and update to the same index the pre-update (old) entry value; no bypass.
REQ-028 SHALL increment BranchCount on every qualifying update (REQ-024) and MispredCount when additionally MispredictD=1; both saturate at all-ones.
REQ-029 SHALL treat a branch held by StallF=1 as unresolved: no update, no count, MispredictD still combinational.

Reset
REQ-030 SHALL, on a clock edge with rst_n=0, clear all valid bits, set all counters to WNT, clear targets/tags to 0, clear PredTakenD, PredTargetD, PCD, BranchCount, MispredCount to 0.
REQ-031 SHALL, during and after reset, drive PredTakenF=0, PredTargetF=0, MispredictD=0 until an entry is allocated.
REQ-032 SHALL let reset override any simultaneous update, stall or flush.

Verification
REQ-033 SHALL verify cold miss: after reset, branch at PC 0x40 resolves taken to 0x20 -> MispredictD=1, RecoverPCD=0x20; next fetch of 0x40 gives PredTakenF=1, PredTargetF=0x20.
REQ-034 SHALL verify hysteresis: entry at WT, one not-taken -> WNT, PredTakenF=0; two taken from WNT -> ST; four not-taken from ST saturates at SNT.
REQ-035 SHALL verify aliasing: PC 0x40 and 0x80 share index 0 -> 0x80 lookup misses (tag), taken 0x80 update replaces entry; 0x40 then predicts not-taken.
REQ-036 SHALL verify stall/flush: StallF=1 with BranchD=1 -> no counter change, counts unchanged; FlushD=1 with BranchD=1 -> MispredictD=0, no update.
REQ-037 SHALL verify same-index read/update: update and lookup of 0x40 in one cycle -> PredTakenF reflects old counter; next cycle reflects new.
REQ-038 SHALL verify counter saturation and mid-run reset: force 0xFFFF branches -> BranchCount holds 0xFFFF; rst_n=0 one cycle -> all counts 0, PredTakenF=0 for every PC.
